xoshiro_prng_gen: RTL and testbench

Parametrised xoshiro PRNG engine for the user-peripheral PRNG slot. It supports two state sizes: W=32 (xoshiro128) and W=64 (xoshiro256). The output scrambler is runtime-selectable (++, **, +), and a multi-cycle jump FSM advances the state by 2^64 (W=32) or 2^128 (W=64) steps. A generator fills an output FIFO, and consumers drain it over a valid/ready handshake.

---
 rtl/xoshiro_prng_gen.sv | 188 ++++++++++++++++++
 tb/tb_xoshiro_prng_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoshiro_prng_gen.sv
// xoshiro128/xoshiro256 PRNG engine: selectable scrambler, bit-serial jump FSM,
// and a small output FIFO drained over a valid/ready handshake.
module xoshiro_prng_gen #(
    parameter int             W          = 32,
    parameter int             FIFO_DEPTH = 4,
    parameter logic [W-1:0]   S0_INIT    = W'(32'h0D1929D2),
    parameter logic [W-1:0]   S1_INIT    = W'(32'h491DFB74),
    parameter logic [W-1:0]   S2_INIT    = W'(32'h473E5E7D),
    parameter logic [W-1:0]   S3_INIT    = W'(32'hD6CA8A07)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         write,
    input  logic [1:0]   write_addr,
    input  logic [W-1:0] write_data,
    input  logic         jump,
    output logic         busy,
    output logic [W-1:0] rnd,
    output logic         rnd_valid,
    input  logic         rnd_ready,
    output logic         state_zero
);

    generate
        if (!(W == 32 || W == 64)) begin : g_bad_width
            $error("xoshiro_prng_gen: W must be 32 or 64");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("xoshiro_prng_gen: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(4 * W);
    localparam int ROT_PP = (W == 32) ? 7 : 23;
    localparam int T_SH   = (W == 32) ? 9 : 17;
    localparam int R_S3   = (W == 32) ? 11 : 45;
    localparam logic [AW:0]    FULL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(4 * W - 1);
    // Jump polynomial words packed with word 0 in the low bits, so bit cnt is JUMP[cnt/W] bit cnt%W.
    localparam logic [4*W-1:0] JUMP_BITS = (W == 32) ?
        (4 * W)'({32'h77F2DB5B, 32'h6FA035C3, 32'hF542D2D3, 32'h8764000B}) :
        (4 * W)'({64'h39ABDC4529B1661C, 64'hA9582618E03FC9AA,
                  64'hD5A61266F0C9392C, 64'h180EC6D33CFD0ABA});

    typedef logic [3:0][W-1:0] state_t;
    typedef enum logic {IDLE, JUMP} fsm_e;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        return (x << n) | (x >> (W - n));
    endfunction

    function automatic logic [W-1:0] scramble(input state_t s, input logic [1:0] md);
        case (md)
            2'd1:    return rotl(s[1] * W'(5), 7) * W'(9);
            2'd2:    return s[0] + s[3];
            default: return rotl(s[0] + s[3], ROT_PP) + s[0];
        endcase
    endfunction

    function automatic state_t step(input state_t s);
        state_t n;
        logic [W-1:0] t;
        t    = s[1] << T_SH;
        n    = s;
        n[2] = n[2] ^ n[0];
        n[3] = n[3] ^ n[1];
        n[1] = n[1] ^ n[2];
        n[0] = n[0] ^ n[3];
        n[2] = n[2] ^ t;
        n[3] = rotl(n[3], R_S3);
        return n;
    endfunction

    state_t                     s_q, s_d, acc_q, acc_d, acc_nxt;
    logic [CW-1:0]              cnt_q, cnt_d;
    fsm_e                       fsm_q, fsm_d;
    logic                       busy_q, busy_d;
    logic                       zero_q, zero_d;
    logic [FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]              wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                count_q, count_d;
    logic [W-1:0]               rnd_q, rnd_d, push_data;
    logic                       push, pop, flush;

    always_comb begin
        s_d       = s_q;
        acc_d     = acc_q;
        acc_nxt   = '0;
        cnt_d     = cnt_q;
        fsm_d     = fsm_q;
        busy_d    = busy_q;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        rnd_d     = rnd_q;
        push      = 1'b0;
        flush     = 1'b0;
        push_data = scramble(s_q, mode);
        pop       = (count_q != '0) && rnd_ready;

        case (fsm_q)
            IDLE: begin
                if (write) begin
                    s_d[write_addr] = write_data;
                    flush           = 1'b1;
                end else if (jump) begin
                    fsm_d  = JUMP;
                    busy_d = 1'b1;
                    acc_d  = '0;
                    cnt_d  = '0;
                    flush  = 1'b1;
                end else if (!zero_q && (count_q != FULL || pop)) begin
                    push = 1'b1;
                    s_d  = step(s_q);
                end
            end
            JUMP: begin
                acc_nxt = JUMP_BITS[cnt_q] ? (acc_q ^ s_q) : acc_q;
                if (cnt_q == LAST_BIT) begin
                    s_d    = acc_nxt;
                    fsm_d  = IDLE;
                    busy_d = 1'b0;
                end else begin
                    acc_d = acc_nxt;
                    s_d   = step(s_q);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase

        // rnd is a registered copy of the head; it only moves when a new head exists.
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW + 1)'(1);
            else if (!push && pop) count_d = count_q - (AW + 1)'(1);
            if (count_d != '0 && (count_q == '0 || pop))
                rnd_d = (pop && count_q > (AW + 1)'(1)) ? mem_q[rd_q + AW'(1)] : push_data;
        end

        zero_d = (s_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= {S3_INIT, S2_INIT, S1_INIT, S0_INIT};
            acc_q   <= '0;
            cnt_q   <= '0;
            fsm_q   <= IDLE;
            busy_q  <= 1'b0;
            zero_q  <= 1'b0;
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rnd_q   <= '0;
        end else begin
            s_q     <= s_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fsm_q   <= fsm_d;
            busy_q  <= busy_d;
            zero_q  <= zero_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            rnd_q   <= rnd_d;
        end
    end

    assign busy       = busy_q;
    assign rnd        = rnd_q;
    assign rnd_valid  = (count_q != '0);
    assign state_zero = zero_q;

endmodule

// File: tb/tb_xoshiro_prng_gen.sv
// Bench for xoshiro_prng_gen: W=32 and W=64 instances checked against a
// software xoshiro reference (next/jump) with randomised consumer back-pressure.
module tb_xoshiro_prng_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, write, jump, busy, rnd_valid, rnd_ready, state_zero;
    logic [1:0]  mode, write_addr;
    logic [31:0] write_data, rnd;

    logic        write64, jump64, busy64, valid64, ready64, zero64;
    logic [1:0]  addr64;
    logic [63:0] wdata64, rnd64;

    int tests = 0;
    int fails = 0;

    logic [31:0] m32[4];
    logic [63:0] m64[4];

    localparam logic [31:0] INIT32 [4] = '{32'h0D1929D2, 32'h491DFB74, 32'h473E5E7D, 32'hD6CA8A07};
    localparam logic [31:0] J32 [4] = '{32'h8764000B, 32'hF542D2D3, 32'h6FA035C3, 32'h77F2DB5B};
    localparam logic [63:0] J64 [4] = '{64'h180EC6D33CFD0ABA, 64'hD5A61266F0C9392C,
                                        64'hA9582618E03FC9AA, 64'h39ABDC4529B1661C};

    xoshiro_prng_gen #(.W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .write(write), .write_addr(write_addr),
        .write_data(write_data), .jump(jump), .busy(busy), .rnd(rnd),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .state_zero(state_zero)
    );

    xoshiro_prng_gen #(.W(64), .FIFO_DEPTH(4),
        .S0_INIT(64'h0123456789ABCDEF), .S1_INIT(64'h0F1E2D3C4B5A6978),
        .S2_INIT(64'hA5A5A5A55A5A5A5A), .S3_INIT(64'h1122334455667788)) dut64 (
        .clk(clk), .rst(rst), .mode(mode), .write(write64), .write_addr(addr64),
        .write_data(wdata64), .jump(jump64), .busy(busy64), .rnd(rnd64),
        .rnd_valid(valid64), .rnd_ready(ready64), .state_zero(zero64)
    );

    // Reference: the published xoshiro128 / xoshiro256 next() and jump().
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction
    function automatic logic [63:0] rotl64(input logic [63:0] x, input int k);
        return (x << k) | (x >> (64 - k));
    endfunction

    function automatic logic [31:0] next32(input int md);
        logic [31:0] r, t;
        if (md == 1)      r = rotl32(m32[1] * 32'd5, 7) * 32'd9;
        else if (md == 2) r = m32[0] + m32[3];
        else              r = rotl32(m32[0] + m32[3], 7) + m32[0];
        t = m32[1] << 9;
        m32[2] ^= m32[0]; m32[3] ^= m32[1]; m32[1] ^= m32[2]; m32[0] ^= m32[3];
        m32[2] ^= t; m32[3] = rotl32(m32[3], 11);
        return r;
    endfunction

    function automatic logic [63:0] next64(input int md);
        logic [63:0] r, t;
        if (md == 1)      r = rotl64(m64[1] * 64'd5, 7) * 64'd9;
        else if (md == 2) r = m64[0] + m64[3];
        else              r = rotl64(m64[0] + m64[3], 23) + m64[0];
        t = m64[1] << 17;
        m64[2] ^= m64[0]; m64[3] ^= m64[1]; m64[1] ^= m64[2]; m64[0] ^= m64[3];
        m64[2] ^= t; m64[3] = rotl64(m64[3], 45);
        return r;
    endfunction

    task automatic jump32_model();
        logic [31:0] a[4];
        logic [31:0] jw;
        a = '{default: 32'h0};
        for (int k = 0; k < 4; k++) begin
            jw = J32[k];
            for (int b = 0; b < 32; b++) begin
                if (jw[b]) for (int i = 0; i < 4; i++) a[i] ^= m32[i];
                void'(next32(0));
            end
        end
        m32 = a;
    endtask

    task automatic jump64_model();
        logic [63:0] a[4];
        logic [63:0] jw;
        a = '{default: 64'h0};
        for (int k = 0; k < 4; k++) begin
            jw = J64[k];
            for (int b = 0; b < 64; b++) begin
                if (jw[b]) for (int i = 0; i < 4; i++) a[i] ^= m64[i];
                void'(next64(0));
            end
        end
        m64 = a;
    endtask

    task automatic seed32(input logic [31:0] v0, v1, v2, v3);
        logic [31:0] v[4];
        v = '{v0, v1, v2, v3};
        rnd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write = 1'b1; write_addr = 2'(i); write_data = v[i];
        end
        @(negedge clk);
        write = 1'b0;
        m32 = v;
    endtask

    task automatic seed64(input logic [63:0] v0, v1, v2, v3);
        logic [63:0] v[4];
        v = '{v0, v1, v2, v3};
        ready64 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write64 = 1'b1; addr64 = 2'(i); wdata64 = v[i];
        end
        @(negedge clk);
        write64 = 1'b0;
        m64 = v;
    endtask

    task automatic wait_valid32();
        int c = 0;
        while (!rnd_valid && c < 20) begin @(negedge clk); c++; end
    endtask

    task automatic stream32(input string nm, input int n, input int md, input bit rr);
        int got = 0;
        int cyc = 0;
        bit r;
        logic [31:0] e;
        while (got < n && cyc < 4000) begin
            @(negedge clk); cyc++;
            r = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            rnd_ready = r;
            if (rnd_valid && r) begin
                e = next32(md); tests++; got++;
                if (rnd !== e) begin
                    fails++; $display("FAIL %s pop %0d: got %h expected %h", nm, got, rnd, e);
                end
            end
        end
        tests++;
        if (got < n) begin fails++; $display("FAIL %s timeout: got %0d of %0d pops", nm, got, n); end
        @(posedge clk); #1 rnd_ready = 1'b0;
    endtask

    task automatic stream64(input string nm, input int n, input bit rr);
        int got = 0;
        int cyc = 0;
        bit r;
        logic [63:0] e;
        while (got < n && cyc < 4000) begin
            @(negedge clk); cyc++;
            r = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            ready64 = r;
            if (valid64 && r) begin
                e = next64(0); tests++; got++;
                if (rnd64 !== e) begin
                    fails++; $display("FAIL %s pop %0d: got %h expected %h", nm, got, rnd64, e);
                end
            end
        end
        tests++;
        if (got < n) begin fails++; $display("FAIL %s timeout: got %0d of %0d pops", nm, got, n); end
        @(posedge clk); #1 ready64 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests += 5;
        if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (rnd_valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
        if (rnd !== 32'h0)       begin fails++; $display("FAIL reset_rnd: got %h expected 0", rnd); end
        if (state_zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b expected 0", state_zero); end
        if (busy64 !== 1'b0)     begin fails++; $display("FAIL reset_busy64: got %b expected 0", busy64); end
        rst = 1'b0;
        @(negedge clk);
        tests += 2;
        if (rnd_valid !== 1'b1)    begin fails++; $display("FAIL first_valid: got %b expected 1", rnd_valid); end
        if (rnd !== 32'hFEF316C3)  begin fails++; $display("FAIL first_word: got %h expected fef316c3", rnd); end
    endtask

    task automatic test_fifo_fill();
        repeat (10) @(negedge clk);
        tests += 2;
        if (rnd_valid !== 1'b1)   begin fails++; $display("FAIL fill_valid: got %b expected 1", rnd_valid); end
        if (rnd !== 32'hFEF316C3) begin fails++; $display("FAIL fill_hold: got %h expected fef316c3", rnd); end
        m32 = INIT32;
        stream32("fill_drain", 100, 0, 1'b1);
    endtask

    task automatic test_seed_pp();
        mode = 2'd0;
        seed32(1, 2, 3, 4);
        wait_valid32();
        tests++;
        if (rnd !== 32'h00000281) begin fails++; $display("FAIL seed_pp_w0: got %h expected 00000281", rnd); end
        rnd_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rnd !== 32'h00180387) begin fails++; $display("FAIL seed_pp_w1: got %h expected 00180387", rnd); end
        void'(next32(0));
        void'(next32(0));
        stream32("seed_pp", 20, 0, 1'b1);
    endtask

    task automatic test_modes();
        mode = 2'd1; seed32(1, 2, 3, 4); wait_valid32();
        tests++;
        if (rnd !== 32'h00002D00) begin fails++; $display("FAIL mode_ss: got %h expected 00002d00", rnd); end
        mode = 2'd2; seed32(1, 2, 3, 4); wait_valid32();
        tests++;
        if (rnd !== 32'h00000005) begin fails++; $display("FAIL mode_p: got %h expected 00000005", rnd); end
        mode = 2'd3; seed32(1, 2, 3, 4); wait_valid32();
        tests++;
        if (rnd !== 32'h00000281) begin fails++; $display("FAIL mode3_pp: got %h expected 00000281", rnd); end
        // Buffered words keep the mode they were generated with.
        mode = 2'd0;
        seed32(32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5CEDC834);
        repeat (8) @(negedge clk);
        mode = 2'd2;
        stream32("mode_switch_old", 4, 0, 1'b1);
        stream32("mode_switch_new", 12, 2, 1'b1);
        mode = 2'd0;
    endtask

    task automatic test_jump32();
        int cnt = 0;
        mode = 2'd0;
        seed32(1, 2, 3, 4);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        while (busy && cnt < 1000) begin
            cnt++;
            // A jump pulse, a write and consumer readiness inside the sequence must all be ignored.
            jump = (cnt == 20); write = (cnt == 40);
            write_addr = 2'd2; write_data = 32'hDEADBEEF;
            rnd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        jump = 1'b0; write = 1'b0; rnd_ready = 1'b0;
        tests += 2;
        if (cnt !== 128)         begin fails++; $display("FAIL jump32_busy_cycles: got %0d expected 128", cnt); end
        if (rnd_valid !== 1'b0)  begin fails++; $display("FAIL jump32_fifo_empty: got %b expected 0", rnd_valid); end
        jump32_model();
        stream32("jump32_stream", 30, 0, 1'b1);
    endtask

    task automatic test_jump64();
        int cnt = 0;
        seed64(64'd1, 64'd2, 64'd3, 64'd4);
        jump64 = 1'b1;
        @(negedge clk);
        jump64 = 1'b0;
        while (busy64 && cnt < 1000) begin
            cnt++;
            jump64 = (cnt == 100);
            ready64 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        jump64 = 1'b0; ready64 = 1'b0;
        tests++;
        if (cnt !== 256) begin fails++; $display("FAIL jump64_busy_cycles: got %0d expected 256", cnt); end
        jump64_model();
        stream64("jump64_stream", 30, 1'b1);
    endtask

    task automatic test_state_zero();
        seed32(0, 0, 0, 0);
        rnd_ready = 1'b1;
        tests += 2;
        if (state_zero !== 1'b1) begin fails++; $display("FAIL zero_flag: got %b expected 1", state_zero); end
        if (rnd_valid !== 1'b0)  begin fails++; $display("FAIL zero_valid: got %b expected 0", rnd_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (rnd_valid !== 1'b0) begin fails++; $display("FAIL zero_halt cycle %0d: got %b expected 0", i, rnd_valid); end
        end
        write = 1'b1; write_addr = 2'd0; write_data = 32'd1;
        @(negedge clk);
        write = 1'b0;
        tests++;
        if (state_zero !== 1'b0) begin fails++; $display("FAIL zero_clear: got %b expected 0", state_zero); end
        m32 = '{32'd1, 32'd0, 32'd0, 32'd0};
        stream32("zero_resume", 20, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        mode = 2'd0;
        seed32(1, 2, 3, 4);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        repeat (49) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midjump_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests += 3;
        if (busy !== 1'b0)      begin fails++; $display("FAIL midjump_rst_busy: got %b expected 0", busy); end
        if (rnd_valid !== 1'b0) begin fails++; $display("FAIL midjump_rst_valid: got %b expected 0", rnd_valid); end
        if (rnd !== 32'h0)      begin fails++; $display("FAIL midjump_rst_rnd: got %h expected 0", rnd); end
        m32 = INIT32;
        stream32("post_jump_reset", 30, 0, 1'b1);
        repeat (2) @(negedge clk);
        tests++;
        if (rnd_valid !== 1'b1) begin fails++; $display("FAIL midfill_valid: got %b expected 1", rnd_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests += 2;
        if (rnd_valid !== 1'b0) begin fails++; $display("FAIL midfill_rst_valid: got %b expected 0", rnd_valid); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL midfill_rst_busy: got %b expected 0", busy); end
        m32 = INIT32;
        stream32("post_fill_reset", 30, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; write = 1'b0; write_addr = 2'd0; write_data = '0;
        jump = 1'b0; rnd_ready = 1'b0;
        write64 = 1'b0; addr64 = 2'd0; wdata64 = '0; jump64 = 1'b0; ready64 = 1'b0;
        test_reset();
        test_fifo_fill();
        test_seed_pp();
        test_modes();
        test_jump32();
        test_jump64();
        test_state_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
